// File: rtl/sdram_tg_pkg.sv
// rtl/sdram_tg_pkg.sv - shared types, mode constants and LFSR tap table for the traffic checker
package sdram_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_GAP,
    ST_RD_REQ,
    ST_RD_GAP,
    ST_FINISH
  } state_t;

  localparam logic MODE_INC  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  // Right-shift Galois toggle masks for maximal-length sequences, 8..32 bits.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_B400;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/sdram_traffic_checker_if.sv
// rtl/sdram_traffic_checker_if.sv - host-port bus between the traffic checker and the SDRAM controller
interface sdram_traffic_checker_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 24
);
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic              rd_pending;

  modport master (
    output wr, rd, addr, wdata,
    input  rdata, done, rd_pending
  );

  modport slave (
    input  wr, rd, addr, wdata,
    output rdata, done, rd_pending
  );
endinterface

// File: rtl/sdram_tg_pattern.sv
// rtl/sdram_tg_pattern.sv - regenerates the data pattern (incrementing or Galois LFSR) word by word
module sdram_tg_pattern
  import sdram_tg_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              mode_in,
  input  logic [DATA_W-1:0] seed_in,
  input  logic              restart,
  input  logic              advance,
  output logic [DATA_W-1:0] word
);

  localparam logic [31:0]       TAPS_ALL = lfsr_taps(DATA_W);
  localparam logic [DATA_W-1:0] TAPS     = TAPS_ALL[DATA_W-1:0];

  logic              mode_q;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] word_next;

  // An all-zero LFSR state would lock up, so a zero seed starts from 1 instead.
  function automatic logic [DATA_W-1:0] first_word(input logic m, input logic [DATA_W-1:0] s);
    if (m == MODE_LFSR && s == '0) return DATA_W'(1);
    return s;
  endfunction

  // Next word of the current sequence.
  always_comb begin
    word_next = word + DATA_W'(1);
    if (mode_q == MODE_LFSR) begin
      word_next = word[0] ? ((word >> 1) ^ TAPS) : (word >> 1);
    end
  end

  // Seed/mode are kept so the read pass can replay the write sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_INC;
      seed_q <= '0;
      word   <= '0;
    end else if (load) begin
      mode_q <= mode_in;
      seed_q <= seed_in;
      word   <= first_word(mode_in, seed_in);
    end else if (restart) begin
      word   <= first_word(mode_q, seed_q);
    end else if (advance) begin
      word   <= word_next;
    end
  end

endmodule

// File: rtl/sdram_traffic_checker.sv
// rtl/sdram_traffic_checker.sv - write-then-read-back traffic generator and checker for the SDRAM host port
module sdram_traffic_checker
  import sdram_tg_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 24,
  parameter int unsigned       NUM_WORDS  = 256,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int                TIMEOUT    = 1023,
  parameter int                ERR_W      = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic                mode_i,
  input  logic [DATA_W-1:0]   seed_i,
  sdram_traffic_checker_if.master host,
  output logic                busy_o,
  output logic                pass_o,
  output logic                fail_o,
  output logic                timeout_o,
  output logic [ERR_W-1:0]    err_count_o,
  output logic [ADDR_W-1:0]   first_err_addr_o
);

  localparam int                TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

  logic [1:0]        rst_sync;
  logic              rst_n;
  state_t            state, state_next;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] addr_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              wr_q, rd_q;
  logic              pat_load, pat_restart, pat_advance;
  logic              tmo_hit, rd_check;
  logic              last_idx, tmo_expire;
  logic [DATA_W-1:0] pat_word;

  // Reset asserts asynchronously and releases two clocks after rst_n_i rises.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign last_idx   = (idx == LAST_IDX);
  assign tmo_expire = !host.rd_pending && (tmo_cnt == TMO_LAST);

  sdram_tg_pattern #(.DATA_W(DATA_W)) u_pattern (
    .clk     (clk_i),
    .rst_n   (rst_n),
    .load    (pat_load),
    .mode_in (mode_i),
    .seed_in (seed_i),
    .restart (pat_restart),
    .advance (pat_advance),
    .word    (pat_word)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state plus one-cycle strobes to the pattern and datapath; done wins over timeout.
  always_comb begin
    state_next  = state;
    pat_load    = 1'b0;
    pat_restart = 1'b0;
    pat_advance = 1'b0;
    tmo_hit     = 1'b0;
    rd_check    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_next = ST_WR_REQ;
          pat_load   = 1'b1;
        end
      end
      ST_WR_REQ: begin
        if (host.done) begin
          state_next = ST_WR_GAP;
        end else if (tmo_expire) begin
          state_next = ST_FINISH;
          tmo_hit    = 1'b1;
        end
      end
      ST_WR_GAP: begin
        if (last_idx) begin
          pat_restart = 1'b1;
          state_next  = ST_RD_REQ;
        end else begin
          pat_advance = 1'b1;
          state_next  = ST_WR_REQ;
        end
      end
      ST_RD_REQ: begin
        if (host.done) begin
          rd_check   = 1'b1;
          state_next = ST_RD_GAP;
        end else if (tmo_expire) begin
          state_next = ST_FINISH;
          tmo_hit    = 1'b1;
        end
      end
      ST_RD_GAP: begin
        if (last_idx) begin
          state_next = ST_FINISH;
        end else begin
          pat_advance = 1'b1;
          state_next  = ST_RD_REQ;
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Counters, registered request outputs and sticky results.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      idx              <= '0;
      addr_q           <= '0;
      tmo_cnt          <= '0;
      wr_q             <= 1'b0;
      rd_q             <= 1'b0;
      busy_o           <= 1'b0;
      pass_o           <= 1'b0;
      fail_o           <= 1'b0;
      timeout_o        <= 1'b0;
      err_count_o      <= '0;
      first_err_addr_o <= '0;
    end else begin
      wr_q <= (state_next == ST_WR_REQ);
      rd_q <= (state_next == ST_RD_REQ);

      // Counts cycles spent waiting in one request; frozen while a read is in flight.
      if ((state == ST_WR_REQ || state == ST_RD_REQ) && state_next == state) begin
        if (!host.rd_pending) tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
        tmo_cnt <= '0;
      end

      if (pat_load) begin
        busy_o           <= 1'b1;
        pass_o           <= 1'b0;
        fail_o           <= 1'b0;
        timeout_o        <= 1'b0;
        err_count_o      <= '0;
        first_err_addr_o <= '0;
        idx              <= '0;
        addr_q           <= START_ADDR;
      end

      if (state == ST_WR_GAP || state == ST_RD_GAP) begin
        if (last_idx) begin
          idx    <= '0;
          addr_q <= START_ADDR;
        end else begin
          idx    <= idx + ADDR_W'(1);
          addr_q <= addr_q + ADDR_W'(1);
        end
      end

      if (rd_check && host.rdata != pat_word) begin
        if (err_count_o != '1) err_count_o <= err_count_o + ERR_W'(1);
        if (err_count_o == '0) first_err_addr_o <= addr_q;
      end

      if (tmo_hit) timeout_o <= 1'b1;

      if (state == ST_FINISH) begin
        pass_o <= (err_count_o == '0) && !timeout_o;
        fail_o <= !((err_count_o == '0) && !timeout_o);
        busy_o <= 1'b0;
      end
    end
  end

  assign host.wr    = wr_q;
  assign host.rd    = rd_q;
  assign host.addr  = addr_q;
  assign host.wdata = pat_word;

endmodule

// File: tb/tb_sdram_traffic_checker.sv
// tb/tb_sdram_traffic_checker.sv - scoreboard bench with a latency-programmable controller model
module tb_sdram_traffic_checker;

  localparam int DW = 16;
  localparam int AW = 24;

  typedef struct packed {
    logic          is_rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } sb_item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start [2];
  logic          mode  [2];
  logic [DW-1:0] seed  [2];
  logic          busy  [2];
  logic          pass  [2];
  logic          fail  [2];
  logic          tmo   [2];
  logic [15:0]   errc  [2];
  logic [AW-1:0] ferr  [2];
  int            lat   [2];
  logic          no_done [2];
  logic          corrupt [2];
  logic          pend    [2];

  sb_item_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nw(input int g);
    return (g == 0) ? 4 : 8;
  endfunction

  function automatic logic [AW-1:0] base(input int g);
    return (g == 0) ? 24'h000000 : 24'hFFFFFE;
  endfunction

  // x^16+x^14+x^13+x^11+1 right-shift Galois form.
  function automatic logic [DW-1:0] pat(input logic m, input logic [DW-1:0] s, input int i);
    logic [DW-1:0] w;
    if (!m) return s + DW'(i);
    w = (s == '0) ? 16'h0001 : s;
    for (int k = 0; k < i; k++) w = w[0] ? ((w >> 1) ^ 16'hB400) : (w >> 1);
    return w;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : ch
    sdram_traffic_checker_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    logic          done_r;
    int            cnt;
    logic [DW-1:0] mem [16];
    logic          flip;

    sdram_traffic_checker #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_WORDS((g == 0) ? 4 : 8),
      .START_ADDR((g == 0) ? 24'h000000 : 24'hFFFFFE), .TIMEOUT(15), .ERR_W(16)
    ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start[g]), .mode_i(mode[g]), .seed_i(seed[g]),
      .host(bus.master), .busy_o(busy[g]), .pass_o(pass[g]), .fail_o(fail[g]),
      .timeout_o(tmo[g]), .err_count_o(errc[g]), .first_err_addr_o(ferr[g])
    );

    assign flip            = corrupt[g] && bus.rd && (bus.addr == 24'd2 || bus.addr == 24'd5);
    assign bus.rdata       = mem[bus.addr[3:0]] ^ {{(DW-1){1'b0}}, flip};
    assign bus.done        = no_done[g] ? 1'b0 : ((lat[g] == 0) ? (bus.wr | bus.rd) : done_r);
    assign bus.rd_pending  = pend[g];

    // Controller model: completes a request after lat[g] extra cycles and checks it against the scoreboard.
    always @(negedge clk or negedge rst_n) begin : model
      sb_item_t e;
      if (!rst_n) begin
        done_r = 1'b0;
        cnt    = 0;
      end else if (done_r) begin
        done_r = 1'b0;
      end else if ((bus.wr || bus.rd) && !no_done[g]) begin
        if (cnt == lat[g]) begin
          cnt = 0;
          if (lat[g] != 0) done_r = 1'b1;
          check_eq("sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("req_kind", bus.rd, e.is_rd);
            check_eq("req_addr", bus.addr, e.addr);
            if (bus.wr) begin
              check_eq("wr_data", bus.wdata, e.data);
              mem[bus.addr[3:0]] = bus.wdata;
            end
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic push_run(input int g, input logic m, input logic [DW-1:0] s);
    for (int i = 0; i < nw(g); i++)
      sb.push_back('{is_rd: 1'b0, addr: base(g) + AW'(i), data: pat(m, s, i)});
    for (int i = 0; i < nw(g); i++)
      sb.push_back('{is_rd: 1'b1, addr: base(g) + AW'(i), data: pat(m, s, i)});
  endtask

  task automatic run(input int g, input logic m, input logic [DW-1:0] s, input int l,
                     input logic corr, input int exp_err, input logic [AW-1:0] exp_first,
                     input int restart_at);
    int cyc;
    lat[g] = l;
    corrupt[g] = corr;
    no_done[g] = 1'b0;
    push_run(g, m, s);
    @(negedge clk);
    start[g] = 1'b1; mode[g] = m; seed[g] = s;
    @(negedge clk);
    start[g] = 1'b0; mode[g] = ~m; seed[g] = ~s;
    check_eq("busy_set", busy[g], 1);
    cyc = 0;
    while (busy[g] && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == restart_at) begin
        start[g] = 1'b1; seed[g] = 16'h5555;
      end else begin
        start[g] = 1'b0;
      end
    end
    check_eq("run_in_budget", cyc < 3000, 1);
    check_eq("sb_drained", sb.size(), 0);
    sb.delete();
    check_eq("pass", pass[g], exp_err == 0);
    check_eq("fail", fail[g], exp_err != 0);
    check_eq("timeout", tmo[g], 0);
    check_eq("err_count", errc[g], exp_err);
    check_eq("first_err_addr", ferr[g], exp_first);
    corrupt[g] = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0; mode[g] = 1'b0; seed[g] = '0; lat[g] = 1;
      no_done[g] = 1'b0; corrupt[g] = 1'b0; pend[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_status0", {busy[0], pass[0], fail[0], tmo[0], errc[0], ferr[0]}, 0);
    check_eq("rst_bus0", {ch[0].bus.wr, ch[0].bus.rd, ch[0].bus.addr, ch[0].bus.wdata}, 0);
    check_eq("rst_status1", {busy[1], pass[1], fail[1], tmo[1], errc[1], ferr[1]}, 0);
    check_eq("rst_bus1", {ch[1].bus.wr, ch[1].bus.rd, ch[1].bus.addr, ch[1].bus.wdata}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    run(0, 1'b0, 16'h00FA, 3, 1'b0, 0, 24'h0, -1);
    run(0, 1'b1, 16'h0000, 1, 1'b0, 0, 24'h0, -1);
    run(0, 1'b0, 16'hFFFE, 0, 1'b0, 0, 24'h0, -1);
    run(1, 1'b0, 16'h1234, 2, 1'b1, 2, 24'h000002, -1);
    run(1, 1'b1, 16'hACE1, 1, 1'b0, 0, 24'h0, 12);

    // Request that never completes must be dropped after exactly 15 cycles.
    no_done[0] = 1'b1;
    @(negedge clk); start[0] = 1'b1; mode[0] = 1'b0; seed[0] = 16'h0;
    @(negedge clk); start[0] = 1'b0;
    n = 0;
    while (ch[0].bus.wr && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_eq("tmo_req_cycles", n, 15);
    check_eq("tmo_flag", tmo[0], 1);
    @(negedge clk);
    check_eq("tmo_busy", busy[0], 0);
    check_eq("tmo_fail", fail[0], 1);
    check_eq("tmo_pass", pass[0], 0);
    check_eq("tmo_wr", ch[0].bus.wr, 0);

    // A read in flight freezes the timeout counter.
    pend[0] = 1'b1;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("pend_no_tmo", {tmo[0], busy[0], ch[0].bus.wr}, 3'b011);
    pend[0] = 1'b0;
    n = 0;
    while (busy[0] && n < 30) begin
      n++;
      @(negedge clk);
    end
    check_eq("pend_release_tmo", {busy[0], tmo[0], fail[0]}, 3'b011);
    no_done[0] = 1'b0;

    // Reset in the middle of a read request.
    lat[0] = 3;
    push_run(0, 1'b0, 16'h0100);
    @(negedge clk); start[0] = 1'b1; mode[0] = 1'b0; seed[0] = 16'h0100;
    @(negedge clk); start[0] = 1'b0;
    n = 0;
    while (!ch[0].bus.rd && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_eq("reached_rd_req", ch[0].bus.rd, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_rd_drop", ch[0].bus.rd, 0);
    check_eq("rst_mid_status", {busy[0], pass[0], fail[0], tmo[0], errc[0], ferr[0]}, 0);
    check_eq("rst_mid_bus", {ch[0].bus.wr, ch[0].bus.rd, ch[0].bus.addr, ch[0].bus.wdata}, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run(0, 1'b1, 16'h00FA, 2, 1'b0, 0, 24'h0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
